// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared widths, fetch state encoding and IF/ID entry packing
package mips_pkg;

    localparam int          WORD_W  = 32;
    localparam int          IFID_W  = 64;
    localparam logic [31:0] PC_STEP = 32'd4;

    // Fetch control states; HALT is only reachable when alignment checking is built in
    typedef enum logic [1:0] {
        RUN   = 2'd0,
        FLUSH = 2'd1,
        HALT  = 2'd2
    } fetch_state_t;

    // One IF/ID word: pc in the upper half, instruction in the lower half
    typedef struct packed {
        logic [WORD_W-1:0] pc;
        logic [WORD_W-1:0] instr;
    } ifid_entry_t;

    function automatic ifid_entry_t pack_ifid(input logic [WORD_W-1:0] pc,
                                              input logic [WORD_W-1:0] instr);
        ifid_entry_t e;
        e.pc    = pc;
        e.instr = instr;
        return e;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - synchronous FIFO of IF/ID entries with push, pop, flush and count
module fetch_fifo
    import mips_pkg::*;
#(
    parameter int DEPTH = 4
)(
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  ifid_entry_t                push_data,
    input  logic                       pop,
    input  logic                       flush,
    output ifid_entry_t                head,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       empty,
    output logic                       full
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    ifid_entry_t   mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [CW-1:0] cnt;
    logic          do_push;
    logic          do_pop;

    // Flush wins over everything; a pop lets a push land in a full FIFO
    assign empty   = (cnt == '0);
    assign full    = (cnt == CW'(DEPTH));
    assign do_pop  = pop & ~empty & ~flush;
    assign do_push = push & ~flush & (~full | do_pop);
    assign count   = cnt;
    assign head    = mem[rd_ptr];

    // Pointer and occupancy bookkeeping; depth is a power of two so pointers wrap freely
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            cnt <= cnt + CW'(do_push) - CW'(do_pop);
        end
    end

    // Entry storage, written only on an accepted push
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - IF stage: PC, in-order imem fetch, IF/ID buffer, redirect squash (option IFU_ALIGN_CHECK_EN)
module instr_fetch_unit
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC        = 32'h0000_0000,
    parameter int          FIFO_DEPTH      = 4,
    parameter int          MAX_OUTSTANDING = 2
)(
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_instr,
    output logic        misalign_err
);

    localparam int OW  = $clog2(MAX_OUTSTANDING + 1);
    localparam int FCW = $clog2(FIFO_DEPTH) + 1;

    fetch_state_t   state;
    fetch_state_t   state_nxt;
    logic [31:0]    fetch_pc;
    logic [31:0]    rsp_pc;
    logic [OW-1:0]  outstanding;
    logic [OW-1:0]  outstanding_nxt;
    logic [OW-1:0]  stale;
    logic [OW-1:0]  stale_nxt;
    logic [31:0]    target_pc;
    logic           redirect_bad;
    logic           issue_fire;
    logic           rsp_take;
    logic           fifo_push;
    logic           fifo_pop;
    logic           fifo_empty;
    logic           fifo_full;
    logic [FCW-1:0] fifo_count;
    ifid_entry_t    fifo_head;

    // Targets are always word aligned internally; the low bits only feed the error check
`ifdef IFU_ALIGN_CHECK_EN
    assign target_pc    = {redirect_pc[31:2], 2'b00};
    assign redirect_bad = redirect_valid & (redirect_pc[1:0] != 2'b00);
`else
    logic unused_redirect_lsbs;
    assign unused_redirect_lsbs = ^redirect_pc[1:0];
    assign target_pc            = {redirect_pc[31:2], 2'b00};
    assign redirect_bad         = 1'b0;
`endif

    // A response with nothing in flight cannot be ours; ignoring it keeps the counter sane
    assign issue_fire      = imem_req_valid & imem_req_ready;
    assign rsp_take        = imem_rsp_valid & (outstanding != '0);
    assign outstanding_nxt = outstanding + OW'(issue_fire) - OW'(rsp_take);

    // Wrong-path words: on redirect everything still in flight becomes stale
    always_comb begin
        stale_nxt = stale;
        if (redirect_valid)
            stale_nxt = outstanding_nxt;
        else if (rsp_take && (stale != '0))
            stale_nxt = stale - OW'(1);
    end

    assign fifo_push = rsp_take & ~redirect_valid & (stale == '0);
    assign fifo_pop  = out_valid & out_ready;

    // Fetch state register
    always_ff @(posedge clk) begin
        if (rst) state <= RUN;
        else     state <= state_nxt;
    end

    // Next fetch state: redirects drain in FLUSH, a bad target parks the unit in HALT
    always_comb begin
        state_nxt = state;
        case (state)
            RUN: begin
                if (redirect_valid && (outstanding_nxt != '0)) state_nxt = FLUSH;
            end
            FLUSH: begin
                if (redirect_valid)
                    state_nxt = (outstanding_nxt != '0) ? FLUSH : RUN;
                else if (stale_nxt == '0)
                    state_nxt = RUN;
            end
`ifdef IFU_ALIGN_CHECK_EN
            HALT:    state_nxt = HALT;
`endif
            default: state_nxt = RUN;
        endcase
        if (redirect_bad) state_nxt = HALT;
    end

    // Outputs: issue only in RUN with both the in-flight limit and FIFO credit available
    always_comb begin
        imem_req_valid = ~rst & (state == RUN) & ~redirect_valid
                       & (int'(outstanding) < MAX_OUTSTANDING)
                       & ((int'(fifo_count) + int'(outstanding)) < FIFO_DEPTH);
        imem_req_addr  = fetch_pc;
        out_valid      = ~rst & ~fifo_empty & ~redirect_valid;
        out_pc         = (rst | fifo_empty) ? 32'h0 : fifo_head.pc;
        out_instr      = (rst | fifo_empty) ? 32'h0 : fifo_head.instr;
    end

    // PC, response-PC shadow and request counters
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc    <= RESET_PC;
            rsp_pc      <= RESET_PC;
            outstanding <= '0;
            stale       <= '0;
        end else begin
            outstanding <= outstanding_nxt;
            stale       <= stale_nxt;
            if (redirect_valid) begin
                fetch_pc <= target_pc;
                rsp_pc   <= target_pc;
            end else begin
                if (issue_fire) fetch_pc <= fetch_pc + PC_STEP;
                if (fifo_push)  rsp_pc   <= rsp_pc + PC_STEP;
            end
        end
    end

`ifdef IFU_ALIGN_CHECK_EN
    // Sticky misaligned-target flag, cleared only by reset
    always_ff @(posedge clk) begin
        if (rst)               misalign_err <= 1'b0;
        else if (redirect_bad) misalign_err <= 1'b1;
    end
`else
    assign misalign_err = 1'b0;
`endif

    fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_data (pack_ifid(rsp_pc, imem_rsp_data)),
        .pop       (fifo_pop),
        .flush     (redirect_valid),
        .head      (fifo_head),
        .count     (fifo_count),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - randomized self-checking bench for instr_fetch_unit
module tb_instr_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          FIFO_DEPTH = 4;
    localparam int          MAX_OUT    = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = 32'h0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic        misalign_err;

    always #5 clk = ~clk;

    instr_fetch_unit #(
        .RESET_PC(RESET_PC), .FIFO_DEPTH(FIFO_DEPTH), .MAX_OUTSTANDING(MAX_OUT)
    ) dut (
        .clk(clk), .rst(rst),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_instr(out_instr),
        .misalign_err(misalign_err)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference state: program-order expectations and an in-order memory
    logic [31:0] mq_addr[$];
    int          mq_due[$];
    logic [31:0] popped[$];
    logic [31:0] exp_out_pc;
    logic [31:0] exp_req_pc;
    logic [31:0] prev_req_addr;
    int          cyc;
    int          lat_lo;
    int          lat_hi;
    int          pops;
    int          total_pops;
    int          first_pop_cyc;
    logic        saw_wrap;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        redirect_valid = 1'b0;
        out_ready = 1'b0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("rst_req_valid", 32'(imem_req_valid), 32'h0);
        check_eq("rst_out_valid", 32'(out_valid), 32'h0);
        check_eq("rst_req_addr", imem_req_addr, RESET_PC);
        check_eq("rst_misalign", 32'(misalign_err), 32'h0);
        rst = 1'b0;
        mq_addr.delete();
        mq_due.delete();
        popped.delete();
        exp_out_pc    = RESET_PC;
        exp_req_pc    = RESET_PC;
        prev_req_addr = 32'h0;
        cyc           = 0;
        pops          = 0;
        first_pop_cyc = -1;
        saw_wrap      = 1'b0;
    endtask

    // One clock cycle: drive at negedge, sample 1ns later, update the model, advance
    task automatic step(input logic rd, input logic [31:0] tgt, input logic ordy, input logic qrdy);
        logic rsp_now;
        logic [31:0] t;
        redirect_valid = rd;
        redirect_pc    = tgt;
        out_ready      = ordy;
        imem_req_ready = qrdy;
        rsp_now        = (mq_addr.size() > 0) && (mq_due[0] <= cyc);
        imem_rsp_valid = rsp_now;
        imem_rsp_data  = rsp_now ? mem_word(mq_addr[0]) : $urandom;
        #1;
        t = {tgt[31:2], 2'b00};
        if (rd) begin
            check_eq("req_valid_on_redirect", 32'(imem_req_valid), 32'h0);
            check_eq("out_valid_on_redirect", 32'(out_valid), 32'h0);
        end
        if (rsp_now) begin
            void'(mq_addr.pop_front());
            void'(mq_due.pop_front());
        end
        if (imem_req_valid && imem_req_ready) begin
            check_eq("req_addr", imem_req_addr, exp_req_pc);
            if (prev_req_addr == 32'hFFFF_FFFC && imem_req_addr == 32'h0) saw_wrap = 1'b1;
            prev_req_addr = imem_req_addr;
            exp_req_pc    = exp_req_pc + 32'd4;
            mq_addr.push_back(imem_req_addr);
            mq_due.push_back(cyc + int'($urandom_range(lat_hi, lat_lo)));
            check_eq("outstanding_bound", 32'(mq_addr.size() <= MAX_OUT), 32'h1);
        end
        if (out_valid && out_ready) begin
            check_eq("out_pc", out_pc, exp_out_pc);
            check_eq("out_instr", out_instr, mem_word(exp_out_pc));
            exp_out_pc = exp_out_pc + 32'd4;
            popped.push_back(out_pc);
            pops++;
            total_pops++;
            if (first_pop_cyc < 0) first_pop_cyc = cyc;
        end
        if (rd) begin
            exp_out_pc = t;
            exp_req_pc = t;
        end
        check_eq("fifo_overflow", 32'(dut.u_fifo.push & dut.u_fifo.full), 32'h0);
        @(negedge clk);
        cyc++;
    endtask

    initial begin
        int mark;
        logic found;
        total_pops = 0;
        lat_lo = 1;
        lat_hi = 1;
        do_reset();

        // 1: back-to-back fetch with single-cycle memory
        repeat (6) step(1'b0, 32'h0, 1'b1, 1'b1);
        check_eq("t1_pop_count", 32'(pops), 32'd4);
        check_eq("t1_first_pop_cycle", 32'(first_pop_cyc), 32'd2);
        check_eq("t1_fourth_pc", (popped.size() >= 4) ? popped[3] : 32'hDEAD_BEEF, 32'd12);

        // 2: decode stall fills the buffer and halts issue
        repeat (10) step(1'b0, 32'h0, 1'b0, 1'b1);
        check_eq("t2_stall_no_issue", 32'(imem_req_valid), 32'h0);
        check_eq("t2_stall_out_valid", 32'(out_valid), 32'h1);
        mark = pops;
        repeat (8) step(1'b0, 32'h0, 1'b1, 1'b0);
        check_eq("t2_buffered_entries", 32'(pops - mark), 32'd4);
        repeat (10) step(1'b0, 32'h0, 1'b1, 1'b1);

        // 3: redirect with two requests in flight
        lat_lo = 3;
        lat_hi = 3;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (mq_addr.size() == 2) found = 1'b1;
            else step(1'b0, 32'h0, 1'b1, 1'b1);
        end
        check_eq("t3_two_in_flight", 32'(found), 32'h1);
        mark = pops;
        step(1'b1, 32'h0000_0100, 1'b1, 1'b1);
        repeat (14) step(1'b0, 32'h0, 1'b1, 1'b1);
        check_eq("t3_first_pc", (popped.size() > mark) ? popped[mark] : 32'hDEAD_BEEF, 32'h100);
        check_eq("t3_second_pc", (popped.size() > mark + 1) ? popped[mark + 1] : 32'hDEAD_BEEF, 32'h104);

        // 4: redirect coinciding with a response and a pop
        lat_lo = 1;
        lat_hi = 1;
        repeat (6) step(1'b0, 32'h0, 1'b1, 1'b1);
        check_eq("t4_setup", 32'((mq_addr.size() > 0) && (mq_due[0] <= cyc) && out_valid), 32'h1);
        mark = pops;
        step(1'b1, 32'h0000_0200, 1'b1, 1'b1);
        check_eq("t4_no_consume", 32'(pops - mark), 32'h0);
        repeat (6) step(1'b0, 32'h0, 1'b1, 1'b1);
        check_eq("t4_first_pc", (popped.size() > mark) ? popped[mark] : 32'hDEAD_BEEF, 32'h200);

        // 5: fetch address wraps past the top of memory
        step(1'b1, 32'hFFFF_FFF8, 1'b1, 1'b1);
        repeat (8) step(1'b0, 32'h0, 1'b1, 1'b1);
        check_eq("t5_addr_wrap", 32'(saw_wrap), 32'h1);

`ifdef IFU_ALIGN_CHECK_EN
        // 6: misaligned target halts the unit until reset
        step(1'b1, 32'h0000_0102, 1'b1, 1'b1);
        check_eq("t6_misalign_set", 32'(misalign_err), 32'h1);
        for (int i = 0; i < 12; i++) begin
            step(1'b0, 32'h0, 1'b1, 1'b1);
            check_eq("t6_halt_no_issue", 32'(imem_req_valid), 32'h0);
        end
        do_reset();
`else
        step(1'b1, 32'h0000_0102, 1'b1, 1'b1);
        check_eq("t6_no_misalign", 32'(misalign_err), 32'h0);
        mark = pops;
        repeat (6) step(1'b0, 32'h0, 1'b1, 1'b1);
        check_eq("t6_forced_align", (popped.size() > mark) ? popped[mark] : 32'hDEAD_BEEF, 32'h100);
`endif

        // Random traffic: stalls, backpressure, variable latency, redirects, resets
        lat_lo = 1;
        lat_hi = 4;
        mark = total_pops;
        for (int i = 0; i < 1500; i++) begin
            logic        rd;
            logic [31:0] tgt;
            if ($urandom_range(499, 0) == 0) do_reset();
            rd  = ($urandom_range(19, 0) == 0);
            tgt = $urandom;
`ifdef IFU_ALIGN_CHECK_EN
            tgt[1:0] = 2'b00;
`endif
            step(rd, tgt, ($urandom_range(9, 0) < 7), ($urandom_range(9, 0) < 7));
        end
        check_eq("random_progress", 32'((total_pops - mark) > 100), 32'h1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
